data_memory_be: RTL
===================

# data_memory_be

Byte-addressed, byte-enable data memory for the MEM stage of the 5-stage pipeline. It replaces the fixed-width single-port data RAM with a block that is parametrised in width and depth. Added behaviour:
- load/store size selection (byte/half/word/double) with sign or zero extension
- misalignment detection
- selectable read-first or write-first store response
- a post-reset clear sequencer that zeroes the whole array before accepting requests

## Interface
- DATA_WIDTH, 32, word width in bits; 32 or 64 only.
- ADDRESS_WIDTH, 10, byte-address width; WORDS = 2^ADDRESS_WIDTH / (DATA_WIDTH/8).
- READ_FIRST, 0, 1: a store returns the old field; 0: a store returns the newly written field.
- CLEAR_ON_RESET, 1, 1: zero all words after reset; 0: array contents are undefined and busy never asserts.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; accepted on a rising edge when req=1 and busy=0.
- we  in  1  1 = store, 0 = load.
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- unsigned_ld  in  1  1 = zero-extend the load/return field, 0 = sign-extend.
- addr  in  ADDRESS_WIDTH  byte address.
- wdata  in  DATA_WIDTH  store data, right-aligned (field in the low bits).
- rdata  out  DATA_WIDTH  extended return field.
- rvalid  out  1  one-cycle pulse: response for the previously accepted request.
- misaligned  out  1  qualifies rvalid: the request was rejected.
- busy  out  1  clear sequence in progress; requests are ignored.

## Operation
- Address split:
  - offset = addr[log2(DATA_WIDTH/8)-1:0]
  - index = addr[ADDRESS_WIDTH-1:log2(DATA_WIDTH/8)]
- Field width = 8·2^size bits.
- Misaligned when either holds:
  - offset is not a multiple of 2^size
  - 2^size > DATA_WIDTH/8 (size=3 with DATA_WIDTH=32)
- Load: the field at bits [offset·8 +: fieldwidth] of mem[index] is shifted to bit 0 and extended per unsigned_ld.
- Store: only the byte lanes covered by the field are written, taking wdata's low fieldwidth bits. Other lanes are unchanged.
- Store response: every accepted store also produces rvalid.
  - rdata = the extended old field when READ_FIRST=1.
  - rdata = the extended new field when READ_FIRST=0.
- Misaligned request: memory is not modified. The next cycle gives rvalid=1, misaligned=1, rdata=0.
- Clear FSM, states CLEAR and READY:
  - CLEAR: counter runs 0..WORDS-1 and writes zero to mem[counter] each cycle; busy=1.
  - After the write of WORDS-1, the FSM goes to READY and busy=0.
  - READY persists until reset.
  - With CLEAR_ON_RESET=0, the FSM resets directly into READY.

## Timing
- Reset values: rdata=0, rvalid=0, misaligned=0, clear counter=0. busy=1 if CLEAR_ON_RESET, else 0.
- Reset asserted mid-clear restarts the sweep at word 0.
- Reset asserted with a response pending drops the response; no rvalid follows.
- Clear duration: busy falls after exactly WORDS rising edges following rst_n release. The first request can be accepted on edge WORDS+1.
- Load/store latency is 1. A request accepted at edge N gives rdata/rvalid/misaligned valid after edge N+1, held for one cycle.
- rvalid=0 on any cycle where the previous edge accepted no request.
- Back-to-back requests are supported every cycle with no bubbles.
- A load at edge N+1 to the location stored at edge N returns the stored data.
- A req seen during busy=1 is dropped silently: no response, no write.
- rdata holds its last value when rvalid=0.

## Test plan
- Clear, DATA_WIDTH=32, ADDRESS_WIDTH=6:
  - Release rst_n and count edges: busy=1 for exactly 16 edges, then 0.
  - Then load word at 0x3C: rdata=0x00000000.
- Byte store/sign load:
  - Store word 0x11223344 at 0x08, then store byte 0xF0 at 0x09.
  - Load byte signed at 0x09 → 0xFFFFFFF0.
  - Load byte unsigned at 0x09 → 0x000000F0.
  - Load word at 0x08 → 0x1122F044.
- Half and misalignment:
  - Load half at 0x0A → 0x00001122.
  - Load half at 0x0B → rvalid=1, misaligned=1, rdata=0.
  - Store word at 0x0E → misaligned=1, and a following word load at 0x0C is unchanged.
- Store response mode:
  - Word 0x0 holds 0xAAAAAAAA; store word 0x55555555 there.
  - READ_FIRST=1 → rdata=0xAAAAAAAA.
  - READ_FIRST=0 → rdata=0x55555555.
- Back-to-back and busy:
  - Alternate store/load every cycle for 8 cycles: 8 rvalid pulses, each 1 cycle after its request.
  - req during busy → no rvalid and the array stays zero.
- Reset mid-clear and mid-response:
  - Drop rst_n at clear count 7 → busy stays 1 for 16 more edges after release.
  - Drop rst_n one cycle after a load is accepted → rvalid stays 0.

Source files
------------

// File: rtl/data_memory_be.sv
// Byte-addressed data memory with byte enables, load/store sizing, misalignment
// rejection and a post-reset zero sweep of the whole array.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | sweeping mem[0..WORDS-1] to zero, busy_o=1, requests dropped
// ST_READY | normal operation until the next reset
module data_memory_be #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 10,
   parameter bit READ_FIRST     = 1'b0,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_i,
   input  logic                     we_i,
   input  logic [1:0]               size_i,
   input  logic                     unsigned_ld_i,
   input  logic [ADDRESS_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0]    wdata_i,
   output logic [DATA_WIDTH-1:0]    rdata_o,
   output logic                     rvalid_o,
   output logic                     misaligned_o,
   output logic                     busy_o
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFFW  = $clog2(BYTES);
   localparam int IDXW  = ADDRESS_WIDTH - OFFW;
   localparam int WORDS = 1 << IDXW;
   // Largest size code that fits in one word (2 for 32-bit, 3 for 64-bit).
   localparam logic [1:0] MAX_SIZE = 2'(OFFW);

   typedef enum logic {ST_CLEAR, ST_READY} state_e;

   state_e                 state_q, state_d;
   logic [IDXW-1:0]        clr_cnt_q, clr_cnt_d;
   logic [DATA_WIDTH-1:0]  mem_q [WORDS];

   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   rvalid_q;
   logic                   mis_q;

   logic [OFFW-1:0]        offset;
   logic [IDXW-1:0]        index;
   logic [OFFW+2:0]        shamt;
   logic                   accept;
   logic                   mis;
   logic [DATA_WIDTH-1:0]  fmask;
   logic [DATA_WIDTH-1:0]  old_word;
   logic [DATA_WIDTH-1:0]  old_field;
   logic [DATA_WIDTH-1:0]  new_word;

   // Keeps the field selected by mask and sign- or zero-extends it from its top bit.
   function automatic logic [DATA_WIDTH-1:0] extend_field(
      input logic [DATA_WIDTH-1:0] field,
      input logic [DATA_WIDTH-1:0] mask,
      input logic                  uns
   );
      logic sgn;
      sgn = |(field & mask & ~(mask >> 1));
      return (uns || !sgn) ? (field & mask) : ((field & mask) | ~mask);
   endfunction

   assign offset = addr_i[OFFW-1:0];
   assign index  = addr_i[ADDRESS_WIDTH-1:OFFW];
   assign shamt  = {offset, 3'b000};
   assign busy_o = (state_q == ST_CLEAR);
   assign accept = req_i && (state_q == ST_READY);

   // Field decode, alignment check and merged store word.
   always_comb begin
      // A shift of the full word width yields zero, so the widest size gives an all-ones mask.
      fmask     = ~({DATA_WIDTH{1'b1}} << (8 << size_i));
      mis       = (size_i > MAX_SIZE) ||
                  ((32'(offset) & ((32'd1 << size_i) - 32'd1)) != 32'd0);
      old_word  = mem_q[index];
      old_field = old_word >> shamt;
      new_word  = (old_word & ~(fmask << shamt)) | ((wdata_i & fmask) << shamt);
      rdata_d   = '0;
      if (!mis) begin
         if (we_i && !READ_FIRST) rdata_d = extend_field(wdata_i, fmask, unsigned_ld_i);
         else                     rdata_d = extend_field(old_field, fmask, unsigned_ld_i);
      end
   end

   // Clear sweep sequencing.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDXW'(WORDS - 1)) state_d = ST_READY;
         end
         default: ;
      endcase
   end

   // FSM state and sweep counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Array write port: sweep zeros while clearing, otherwise aligned stores.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR)              mem_q[clr_cnt_q] <= '0;
      else if (accept && we_i && !mis)      mem_q[index]     <= new_word;
   end

   // One-cycle response register; rdata holds between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         rvalid_q <= accept;
         mis_q    <= accept && mis;
         if (accept) rdata_q <= rdata_d;
      end
   end

   assign rdata_o      = rdata_q;
   assign rvalid_o     = rvalid_q;
   assign misaligned_o = mis_q;

endmodule
